// File: rtl/exec_core_if.sv
// rtl/exec_core_if.sv - ALU and branch-comparator signal bundle for exec_core
//
// Groups the operand, opcode and result signals of the execute stage.
//   master : drives operands/opcode/comparator mode, receives results
//   slave  : exec_core side, receives operands, drives results
interface exec_core_if;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [3:0]  i_alu_op;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_br_un;
  logic [31:0] o_alu_data;
  logic        o_br_less;
  logic        o_br_equal;

  modport master (
    output i_op_a, i_op_b, i_alu_op, i_rs1_data, i_rs2_data, i_br_un,
    input  o_alu_data, o_br_less, o_br_equal
  );

  modport slave (
    input  i_op_a, i_op_b, i_alu_op, i_rs1_data, i_rs2_data, i_br_un,
    output o_alu_data, o_br_less, o_br_equal
  );
endinterface

// File: rtl/exec_core.sv
// rtl/exec_core.sv - RV32I execute cluster: ALU, branch comparator, clock divider
//
// Ports:
//   i_clk   : board clock, rising edge
//   i_reset : synchronous active-high reset (divider only)
//   bus     : exec_core_if.slave - ALU operands/result, comparator operands/flags
//   o_clk   : divided core clock, f(i_clk) / (2*HALF_PERIOD), 50% duty
// Parameters:
//   HALF_PERIOD : i_clk cycles per o_clk half-period (>= 1)
//   CNT_W       : divider counter width, 2^CNT_W > HALF_PERIOD
// Build option:
//   EXEC_CLKDIV_BYPASS_EN : o_clk is i_clk passed straight through, no divider
module exec_core #(
  parameter int unsigned HALF_PERIOD = 2500000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  exec_core_if.slave  bus,
  output logic        o_clk
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;

  // Only the low five bits of b select the shift; b[31:5] is ignored.
  logic [4:0] shamt;
  assign shamt = bus.i_op_b[4:0];

  always_comb begin
    bus.o_alu_data = 32'h0;
    case (bus.i_alu_op)
      OP_ADD:  bus.o_alu_data = bus.i_op_a + bus.i_op_b;
      OP_SUB:  bus.o_alu_data = bus.i_op_a - bus.i_op_b;
      OP_SLL:  bus.o_alu_data = bus.i_op_a << shamt;
      OP_SLT:  bus.o_alu_data = {31'b0, $signed(bus.i_op_a) < $signed(bus.i_op_b)};
      OP_SLTU: bus.o_alu_data = {31'b0, bus.i_op_a < bus.i_op_b};
      OP_XOR:  bus.o_alu_data = bus.i_op_a ^ bus.i_op_b;
      OP_SRL:  bus.o_alu_data = bus.i_op_a >> shamt;
      OP_SRA:  bus.o_alu_data = $unsigned($signed(bus.i_op_a) >>> shamt);
      OP_OR:   bus.o_alu_data = bus.i_op_a | bus.i_op_b;
      OP_AND:  bus.o_alu_data = bus.i_op_a & bus.i_op_b;
      OP_PASS: bus.o_alu_data = bus.i_op_b;
      default: bus.o_alu_data = 32'h0;
    endcase
  end

  // Strict less-than in either mode, so equal operands never report less.
  always_comb begin
    bus.o_br_equal = (bus.i_rs1_data == bus.i_rs2_data);
    if (bus.i_br_un)
      bus.o_br_less = (bus.i_rs1_data < bus.i_rs2_data);
    else
      bus.o_br_less = ($signed(bus.i_rs1_data) < $signed(bus.i_rs2_data));
  end

`ifdef EXEC_CLKDIV_BYPASS_EN
  // Full-speed simulation: reset is deliberately unused here.
  logic unused_reset;
  assign unused_reset = i_reset;
  assign o_clk        = i_clk;
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             clk_div;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      clk_div <= ~clk_div;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

  assign o_clk = clk_div;
`endif

endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - directed table-driven bench for exec_core
module tb_exec_core;

  logic clk;
  logic rst;
  logic o_clk;

  int checks;
  int errors;

  exec_core_if bus ();

  exec_core #(
    .HALF_PERIOD (3),
    .CNT_W       (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_clk   (o_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        un;
    logic [31:0] exp_alu;
    logic        exp_less;
    logic        exp_eq;
  } vec_t;

  vec_t vecs [16];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.i_op_a     = v.a;
    bus.i_op_b     = v.b;
    bus.i_alu_op   = v.op;
    bus.i_rs1_data = v.rs1;
    bus.i_rs2_data = v.rs2;
    bus.i_br_un    = v.un;
  endtask

  // Drive reset away from the edge, then sample o_clk 1 time unit after the edge.
  task automatic div_step(input logic r, input logic exp, input string name);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    chk1(name, o_clk, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    //          a             b             op      rs1           rs2           un    alu           lt    eq
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000000, 32'h00000001, 4'b0001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h00000024, 4'b0111, 32'h00001234, 32'h00001234, 1'b0, 32'hF8000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h00000024, 4'b0110, 32'h00001234, 32'h00001234, 1'b1, 32'h08000000, 1'b0, 1'b1};
    vecs[4]  = '{32'h00000001, 32'h00000024, 4'b0010, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000010, 1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0011, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0100, 32'h00000000, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0101, 32'h00000001, 32'h00000000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, 4'b1010, 32'h00000005, 32'h00000009, 1'b0, 32'h00000001, 1'b1, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 4'b1111, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{32'h00000001, 32'h00000020, 4'b0010, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b1};
    vecs[12] = '{32'hF0F0F0F0, 32'h0F0F0000, 4'b1000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'hFFFFF0F0, 1'b0, 1'b0};
    vecs[13] = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1001, 32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h00F000F0, 1'b1, 1'b0};
    vecs[14] = '{32'h00000005, 32'h00000006, 4'b1011, 32'h00000007, 32'h00000003, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vecs[15] = '{32'h40000000, 32'h00000004, 4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h04000000, 1'b0, 1'b1};

    apply(vecs[0]);

`ifdef EXEC_CLKDIV_BYPASS_EN
    // o_clk must follow i_clk in both reset states.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = (k < 2);
      #2;
      chk1("bypass_low", o_clk, clk);
      @(posedge clk);
      #2;
      chk1("bypass_high", o_clk, clk);
    end
    @(negedge clk);
    rst = 1'b0;
`else
    // Reset held for two edges.
    div_step(1'b1, 1'b0, "reset_0");
    div_step(1'b1, 1'b0, "reset_1");

    // Combinational outputs are live during reset.
    chk32("alu_in_reset", bus.o_alu_data, 32'h80000000);

    // After release: edges 1,2 low, toggle on edge 3, high through 5, low on 6.
    for (int k = 1; k <= 12; k++)
      div_step(1'b0, logic'((k / 3) % 2), $sformatf("div_run_%0d", k));

    // Into the high phase: edge 3 rises, edge 4 mid-high.
    for (int k = 1; k <= 4; k++)
      div_step(1'b0, logic'((k / 3) % 2), $sformatf("div_pre_%0d", k));

    // One-edge reset mid-high-phase drops o_clk and discards the partial count.
    div_step(1'b1, 1'b0, "mid_reset");
    for (int k = 1; k <= 7; k++)
      div_step(1'b0, logic'((k / 3) % 2), $sformatf("div_restart_%0d", k));
`endif

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #1;
      chk32($sformatf("alu_%0d", i), bus.o_alu_data, vecs[i].exp_alu);
      chk1($sformatf("br_less_%0d", i), bus.o_br_less, vecs[i].exp_less);
      chk1($sformatf("br_equal_%0d", i), bus.o_br_equal, vecs[i].exp_eq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_core.md
Name: exec_core

Overview:
- Execute-stage cluster of the single-cycle RV32I core: combinational 32-bit ALU, combinational branch comparator, and a clock divider.
- The clock divider produces the slow core clock that drives the PC, regfile and LSU from the 50 MHz board clock.
- ALU and comparator have no state; the divider is the only sequential logic.

Parameters:
- HALF_PERIOD, 2500000, number of i_clk cycles per o_clk half-period. Legal range ≥1. The default gives 10 Hz from 50 MHz.
- CNT_W, 32, width of the divider counter. Must satisfy 2^CNT_W > HALF_PERIOD.

Ports:
- i_clk  input  1  board clock; all sequential logic uses its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_op_a  input  32  ALU operand A (rs1 or PC).
- i_op_b  input  32  ALU operand B (rs2 or immediate).
- i_alu_op  input  4  ALU operation select.
- i_rs1_data  input  32  comparator operand 1.
- i_rs2_data  input  32  comparator operand 2.
- i_br_un  input  1  comparator mode: 1 = unsigned, 0 = signed.
- o_alu_data  output  32  ALU result.
- o_br_less  output  1  rs1 < rs2 under the mode set by i_br_un.
- o_br_equal  output  1  rs1 == rs2.
- o_clk  output  1  divided clock.

Behaviour:
- ALU is purely combinational: zero latency, result valid in the same cycle the inputs are valid. Encoding of i_alu_op:
  - 0000 ADD: a+b, modulo 2^32, carry discarded.
  - 0001 SUB: a−b, modulo 2^32.
  - 0010 SLL: a << b[4:0].
  - 0011 SLT: {31'b0, signed(a) < signed(b)}.
  - 0100 SLTU: {31'b0, a < b unsigned}.
  - 0101 XOR.
  - 0110 SRL: logical shift right by b[4:0].
  - 0111 SRA: arithmetic shift right by b[4:0], sign-filled from a[31].
  - 1000 OR.
  - 1001 AND.
  - 1010 PASS_B: result = b (used for LUI with a = 0).
  - 1011–1111: result 32'h0.
- Shift amount uses only b[4:0]; b[31:5] is ignored, so a shift by 32 equals a shift by 0.
- The ALU ignores i_br_un.
- Branch comparator is purely combinational:
  - o_br_equal = (rs1 == rs2), independent of i_br_un.
  - o_br_less = signed compare when i_br_un=0, unsigned compare when i_br_un=1.
  - When equal, o_br_less = 0.
- Clock divider:
  - Counter cnt (CNT_W bits) and register o_clk.
  - On each i_clk rising edge with i_reset=0: if cnt == HALF_PERIOD−1, then cnt ← 0 and o_clk ← ~o_clk; otherwise cnt ← cnt+1.
  - o_clk frequency = f(i_clk) / (2·HALF_PERIOD), 50% duty cycle.
  - HALF_PERIOD=1 toggles o_clk on every i_clk edge.
- Reset (synchronous, active-high): on a rising i_clk edge with i_reset=1, cnt ← 0 and o_clk ← 0.
  - Reset asserted mid-period discards the partial count.
  - After reset deasserts, the first o_clk rising edge occurs HALF_PERIOD i_clk edges later.
  - Reset does not affect the combinational outputs: o_alu_data, o_br_less and o_br_equal always reflect the current inputs.
- Everything sequential is clocked only by i_clk; no logic is clocked by o_clk inside this block.

Optional Feature:
- Macro EXEC_CLKDIV_BYPASS_EN.
- When defined: counter logic is removed and o_clk is driven directly by i_clk (combinational pass-through). Intended for full-speed simulation and regression. HALF_PERIOD and i_reset have no effect on o_clk.
- When undefined: divider behaves as described in Behaviour.

Test Plan:
- ALU arithmetic: a=32'h7FFFFFFF, b=1, op=0000 → 32'h80000000. a=0, b=1, op=0001 → 32'hFFFFFFFF.
- ALU shifts: a=32'h80000000, b=32'h00000024 (b[4:0]=4):
  - op=0111 → 32'hF8000000.
  - op=0110 → 32'h08000000.
  - op=0010 with a=1 → 32'h00000010.
- ALU set/logic/pass: a=32'hFFFFFFFF, b=1:
  - op=0011 → 1; op=0100 → 0; op=0101 → 32'hFFFFFFFE; op=1010 → 1.
  - op=1111 → 0.
- Comparator: rs1=32'hFFFFFFFF, rs2=1:
  - i_br_un=0 → less=1, equal=0.
  - i_br_un=1 → less=0, equal=0.
  - rs1=rs2=32'h1234 → less=0, equal=1 in both modes.
- Divider: HALF_PERIOD=3. Hold i_reset=1 for 2 edges, then release → o_clk=0 for 3 edges, 1 for 3 edges, and repeats. Assert i_reset for one edge mid-high-phase → o_clk=0 and the count restarts from 0.
- Bypass: compile with EXEC_CLKDIV_BYPASS_EN → o_clk tracks i_clk exactly, including while i_reset=1.
